dotp_sequencer: RTL

- Initiator/controller for the 8-bit signed MAC unit: accepts a dot-product command, streams operand pairs from two synchronous-read operand memories into the MAC, and drives its enable/clear controls.
- Captures the final 32-bit accumulator value and returns it over a valid/ready result channel.
- Sits between the command/control logic and one MAC instance; the parent instantiates both blocks and wires them together.

---
 rtl/dotp_pkg.sv | 23 ++
 rtl/dotp_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/dotp_pkg.sv
// Shared types and constants for the dot-product sequencer: FSM state encoding,
// MAC operand/accumulator widths and the latched command record.
package dotp_pkg;

    localparam int CMD_ADDR_W = 6;
    localparam int MAC_DATA_W = 8;
    localparam int MAC_ACC_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        HOLD
    } state_e;

    typedef struct packed {
        logic [CMD_ADDR_W:0]   len;
        logic [CMD_ADDR_W-1:0] base_a;
        logic [CMD_ADDR_W-1:0] base_b;
    } cmd_t;

endpackage

// File: rtl/dotp_sequencer.sv
// Dot-product sequencer: streams operand pairs from two sync-read memories into an
// external MAC and returns the accumulator. Define DOTP_RELU_EN to clamp negative results to 0.
module dotp_sequencer
    import dotp_pkg::*;
#(
    // The latched command record is sized by CMD_ADDR_W; keep ADDR_W equal to it.
    parameter int ADDR_W = CMD_ADDR_W,
    parameter int DATA_W = MAC_DATA_W,
    parameter int ACC_W  = MAC_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [ADDR_W-1:0] cmd_base_a,
    input  logic [ADDR_W-1:0] cmd_base_b,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_a_addr,
    output logic [ADDR_W-1:0] mem_b_addr,
    input  logic [DATA_W-1:0] mem_a_data,
    input  logic [DATA_W-1:0] mem_b_data,
    output logic              mac_enable,
    output logic              mac_clear,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data
);

    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic              drain_left_q, drain_left_d;
    logic              mac_en_q;
    logic [ACC_W-1:0]  res_q, res_d;
    logic              rd_en;
    logic [ACC_W-1:0]  capture_val;

`ifdef DOTP_RELU_EN
    assign capture_val = mac_acc[ACC_W-1] ? '0 : mac_acc;
`else
    assign capture_val = mac_acc;
`endif

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        issued_d     = issued_q;
        drain_left_d = drain_left_q;
        res_d        = res_q;
        rd_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d.len    = cmd_len;
                    cmd_d.base_a = cmd_base_a;
                    cmd_d.base_b = cmd_base_b;
                    state_d      = CLEAR;
                end
            end
            CLEAR: begin
                // Element 0 is read straight from the bases; the counters carry on from base+1.
                rd_en        = (cmd_q.len != '0);
                addr_a_d     = cmd_q.base_a + ADDR_ONE;
                addr_b_d     = cmd_q.base_b + ADDR_ONE;
                issued_d     = LEN_ONE;
                // An empty vector has nothing in flight, so one drain cycle suffices.
                drain_left_d = (cmd_q.len != '0);
                state_d      = (cmd_q.len > LEN_ONE) ? RUN : DRAIN;
            end
            RUN: begin
                rd_en    = 1'b1;
                addr_a_d = addr_a_q + ADDR_ONE;
                addr_b_d = addr_b_q + ADDR_ONE;
                issued_d = issued_q + LEN_ONE;
                if (issued_q == cmd_q.len - LEN_ONE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_left_q) begin
                    drain_left_d = 1'b0;
                end else begin
                    res_d   = capture_val;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            issued_q     <= '0;
            drain_left_q <= 1'b0;
            mac_en_q     <= 1'b0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            issued_q     <= issued_d;
            drain_left_q <= drain_left_d;
            mac_en_q     <= rd_en;
            res_q        <= res_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign mac_clear  = (state_q == CLEAR);
    assign res_valid  = (state_q == HOLD);
    assign res_data   = res_q;
    assign mem_rd_en  = rd_en;
    assign mem_a_addr = (state_q == CLEAR) ? cmd_q.base_a : addr_a_q;
    assign mem_b_addr = (state_q == CLEAR) ? cmd_q.base_b : addr_b_q;
    assign mac_enable = mac_en_q;
    assign mac_a      = mac_en_q ? mem_a_data : '0;
    assign mac_b      = mac_en_q ? mem_b_data : '0;

endmodule
